video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
// - Parametrised raster timing generator; successor to the fixed sync-pulse generator.
// - Two runtime-selectable modes: mode 0 = Namco System86 (288x224 of 384x264), mode 1 = VGA (640x480 of 800x525).
// - Drives HSync/VSync, HBlank/VBlank, Active, Col/Row and frame/line strobes, all registered and mutually aligned.
// - Sits between the pixel clock domain root and the test pattern / video pipeline; supports a pixel clock enable.
// PARAMETERS
// - COUNT_WIDTH   10   width of o_Col_Count/o_Row_Count; must hold max TOTAL-1 of both modes
// - HSYNC_POL     0    active level of o_HSync (0 = active-low)
// - VSYNC_POL     0    active level of o_VSync (0 = active-low)
// - M0_H_ACT/FP/SYNC/BP  288/32/32/32   mode 0 horizontal region lengths, total 384
// - M0_V_ACT/FP/SYNC/BP  224/8/8/24     mode 0 vertical region lengths, total 264
// - M1_H_ACT/FP/SYNC/BP  640/16/96/48   mode 1 horizontal region lengths, total 800
// - M1_V_ACT/FP/SYNC/BP  480/10/2/33    mode 1 vertical region lengths, total 525
// PORTS
// - i_Clk           in   1            system clock
// - i_Reset         in   1            synchronous, active-high reset
// - i_Pix_En        in   1            pixel clock enable; all state advances only when high
// - i_Mode          in   1            requested mode; applied at the frame boundary
// - o_Mode          out  1            mode currently in effect
// - o_Col_Count     out  COUNT_WIDTH  column of the pixel described this cycle
// - o_Row_Count     out  COUNT_WIDTH  row of the pixel described this cycle
// - o_HSync         out  1            horizontal sync at HSYNC_POL
// - o_VSync         out  1            vertical sync at VSYNC_POL
// - o_HBlank        out  1            high when col >= H_ACT
// - o_VBlank        out  1            high when row >= V_ACT
// - o_Active        out  1            ~o_HBlank & ~o_VBlank
// - o_Line_Start    out  1            one-enable pulse at col 0 of every row
// - o_Frame_Start   out  1            one-enable pulse at col 0, row 0
// BEHAVIOUR
// - Line order: active, front porch, sync, back porch. HSync active for col in [ACT+FP, ACT+FP+SYNC); VSync same rule on row.
// - Counters: col 0..H_TOT-1, wraps to 0 and increments row; row wraps 0 after V_TOT-1. Advance only on i_Pix_En=1.
// - Decode stage: every output registered from the counter state; latency 1 enabled cycle; all outputs coherent for the same (col,row).
// - i_Pix_En=0: counters and every output hold their values; strobes also hold, so each strobe spans one enabled period.
// - Reset (i_Reset=1 at an i_Clk edge, regardless of i_Pix_En): counters=0, o_Mode=i_Mode, syncs at inactive level,
//   o_HBlank=o_VBlank=1, o_Active=0, strobes=0, counts=0.
// - After reset: first enabled edge presents (0,0) with o_Frame_Start=o_Line_Start=1 and o_Active=1.
// - Mode switch: i_Mode sampled on the enabled edge where the counter wraps from (H_TOT-1, V_TOT-1) to (0,0).
//   The new geometry applies from that (0,0). o_Mode changes with the same output update as o_Frame_Start.
//   No partial frame. i_Mode toggles mid-frame that revert before the wrap have no effect.
// - Reset mid-frame: immediate return to reset state; in-flight mode request discarded; mode re-sampled from i_Mode.
// - Simultaneous line and frame wrap: both strobes asserted in the same cycle.
// - Parameter check: elaboration error if ACT+FP+SYNC+BP exceeds 2**COUNT_WIDTH for either mode.
// STRUCTURE
// - video_timing_pkg: mode index constants, a region enum {ACTIVE, FPORCH, SYNC, BPORCH},
//   and a function returning region boundaries for a given mode.
// - Sub-module video_axis_counter (instantiated twice, horizontal and vertical): counter with enable, wrap flag and region decode.
//   The top handles the mode latch, polarity and output register stage.
// TESTING
// - Reset, mode 0, i_Pix_En=1: o_Frame_Start at first edge; HSync low for cols 320..351;
//   VSync low for rows 232..239; 384*264 = 101376 enables per frame.
// - Mode 1 from reset: HBlank rises at col 640; HSync low for cols 656..751; VSync low for rows 490..491; frame = 420000 enables.
// - i_Mode 0->1 at row 100: mode 0 frame completes (row 263 seen); next o_Frame_Start has o_Mode=1 and H total 800.
// - i_Pix_En pattern 1-in-4: outputs change only on enabled edges; o_Frame_Start held high for exactly 4 clocks.
// - i_Reset pulse at (col 200, row 150): next cycle shows reset values; first enabled edge after release shows (0,0) with strobes high.
// - HSYNC_POL=1, VSYNC_POL=1 build: sync polarity inverted, all timing identical to the first scenario.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: mode indices, line/frame
// region encoding and the per-mode region boundary lookup.
package video_timing_pkg;

  localparam logic MODE_S86 = 1'b0;
  localparam logic MODE_VGA = 1'b1;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FPORCH,
    REG_SYNC,
    REG_BPORCH
  } region_e;

  // Start of each region plus the total length of one axis.
  typedef struct packed {
    logic [31:0] fp_start;
    logic [31:0] sync_start;
    logic [31:0] bp_start;
    logic [31:0] total;
  } bounds_t;

  function automatic bounds_t mode_bounds(
    input logic        mode,
    input int unsigned m0_act, input int unsigned m0_fp,
    input int unsigned m0_sync, input int unsigned m0_bp,
    input int unsigned m1_act, input int unsigned m1_fp,
    input int unsigned m1_sync, input int unsigned m1_bp
  );
    bounds_t b;
    if (mode == MODE_VGA) begin
      b.fp_start   = m1_act;
      b.sync_start = m1_act + m1_fp;
      b.bp_start   = m1_act + m1_fp + m1_sync;
      b.total      = m1_act + m1_fp + m1_sync + m1_bp;
    end else begin
      b.fp_start   = m0_act;
      b.sync_start = m0_act + m0_fp;
      b.bp_start   = m0_act + m0_fp + m0_sync;
      b.total      = m0_act + m0_fp + m0_sync + m0_bp;
    end
    return b;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter with enable, terminal-count flag and
// combinational region decode of the current position.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  input  logic [W-1:0] fp_start_i,
  input  logic [W-1:0] sync_start_i,
  input  logic [W-1:0] bp_start_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output region_e      region_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    wrap_o  = (count_q == last_i);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_comb begin
    region_o = REG_BPORCH;
    if (count_q < fp_start_i) begin
      region_o = REG_ACTIVE;
    end else if (count_q < sync_start_i) begin
      region_o = REG_FPORCH;
    end else if (count_q < bp_start_i) begin
      region_o = REG_SYNC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Two-mode raster timing generator: axis counters, frame-boundary mode latch
// and a single registered decode stage so all outputs describe the same pixel.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          COUNT_WIDTH = 10,
  parameter int          HSYNC_POL   = 0,
  parameter int          VSYNC_POL   = 0,
  parameter int unsigned M0_H_ACT    = 288,
  parameter int unsigned M0_H_FP     = 32,
  parameter int unsigned M0_H_SYNC   = 32,
  parameter int unsigned M0_H_BP     = 32,
  parameter int unsigned M0_V_ACT    = 224,
  parameter int unsigned M0_V_FP     = 8,
  parameter int unsigned M0_V_SYNC   = 8,
  parameter int unsigned M0_V_BP     = 24,
  parameter int unsigned M1_H_ACT    = 640,
  parameter int unsigned M1_H_FP     = 16,
  parameter int unsigned M1_H_SYNC   = 96,
  parameter int unsigned M1_H_BP     = 48,
  parameter int unsigned M1_V_ACT    = 480,
  parameter int unsigned M1_V_FP     = 10,
  parameter int unsigned M1_V_SYNC   = 2,
  parameter int unsigned M1_V_BP     = 33
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Pix_En,
  input  logic                   i_Mode,
  output logic                   o_Mode,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_HBlank,
  output logic                   o_VBlank,
  output logic                   o_Active,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start
);

  localparam int unsigned    M0_H_TOT = M0_H_ACT + M0_H_FP + M0_H_SYNC + M0_H_BP;
  localparam int unsigned    M0_V_TOT = M0_V_ACT + M0_V_FP + M0_V_SYNC + M0_V_BP;
  localparam int unsigned    M1_H_TOT = M1_H_ACT + M1_H_FP + M1_H_SYNC + M1_H_BP;
  localparam int unsigned    M1_V_TOT = M1_V_ACT + M1_V_FP + M1_V_SYNC + M1_V_BP;
  localparam longint unsigned CNT_SPAN = 64'd1 << COUNT_WIDTH;
  localparam logic           HS_ON    = (HSYNC_POL != 0);
  localparam logic           VS_ON    = (VSYNC_POL != 0);

  if (({32'd0, M0_H_TOT} > CNT_SPAN) || ({32'd0, M0_V_TOT} > CNT_SPAN) ||
      ({32'd0, M1_H_TOT} > CNT_SPAN) || ({32'd0, M1_V_TOT} > CNT_SPAN)) begin : g_bad_geometry
    $error("video_timing_gen: a mode total exceeds the COUNT_WIDTH counter range");
  end

  logic                   mode_q, mode_d;
  bounds_t                hb, vb;
  logic [COUNT_WIDTH-1:0] h_count, v_count;
  logic                   h_wrap, v_wrap, frame_wrap;
  region_e                h_region, v_region;

  always_comb begin
    hb = mode_bounds(mode_q, M0_H_ACT, M0_H_FP, M0_H_SYNC, M0_H_BP,
                     M1_H_ACT, M1_H_FP, M1_H_SYNC, M1_H_BP);
    vb = mode_bounds(mode_q, M0_V_ACT, M0_V_FP, M0_V_SYNC, M0_V_BP,
                     M1_V_ACT, M1_V_FP, M1_V_SYNC, M1_V_BP);
  end

  video_axis_counter #(.W(COUNT_WIDTH)) u_h_axis (
    .clk_i        (i_Clk),
    .rst_i        (i_Reset),
    .en_i         (i_Pix_En),
    .last_i       (COUNT_WIDTH'(hb.total - 32'd1)),
    .fp_start_i   (COUNT_WIDTH'(hb.fp_start)),
    .sync_start_i (COUNT_WIDTH'(hb.sync_start)),
    .bp_start_i   (COUNT_WIDTH'(hb.bp_start)),
    .count_o      (h_count),
    .wrap_o       (h_wrap),
    .region_o     (h_region)
  );

  video_axis_counter #(.W(COUNT_WIDTH)) u_v_axis (
    .clk_i        (i_Clk),
    .rst_i        (i_Reset),
    .en_i         (i_Pix_En & h_wrap),
    .last_i       (COUNT_WIDTH'(vb.total - 32'd1)),
    .fp_start_i   (COUNT_WIDTH'(vb.fp_start)),
    .sync_start_i (COUNT_WIDTH'(vb.sync_start)),
    .bp_start_i   (COUNT_WIDTH'(vb.bp_start)),
    .count_o      (v_count),
    .wrap_o       (v_wrap),
    .region_o     (v_region)
  );

  // The requested mode is only taken when the counters wrap to (0,0), so a
  // frame never mixes geometries and mid-frame glitches on i_Mode are ignored.
  assign frame_wrap = i_Pix_En & h_wrap & v_wrap;

  always_comb begin
    mode_d = mode_q;
    if (frame_wrap) begin
      mode_d = i_Mode;
    end
  end

  logic                   omode_q, omode_d;
  logic [COUNT_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   hblank_q, hblank_d, vblank_q, vblank_d;
  logic                   active_q, active_d, line_q, line_d, frame_q, frame_d;

  always_comb begin
    omode_d  = mode_q;
    col_d    = h_count;
    row_d    = v_count;
    hsync_d  = (h_region == REG_SYNC) ? HS_ON : ~HS_ON;
    vsync_d  = (v_region == REG_SYNC) ? VS_ON : ~VS_ON;
    hblank_d = (h_region != REG_ACTIVE);
    vblank_d = (v_region != REG_ACTIVE);
    active_d = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    line_d   = (h_count == '0);
    frame_d  = (h_count == '0) && (v_count == '0);
  end

  // Output stage: everything is held while the pixel enable is low.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_q   <= i_Mode;
      omode_q  <= i_Mode;
      col_q    <= '0;
      row_q    <= '0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      active_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else if (i_Pix_En) begin
      mode_q   <= mode_d;
      omode_q  <= omode_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign o_Mode        = omode_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_HBlank      = hblank_q;
  assign o_VBlank      = vblank_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_q;
  assign o_Frame_Start = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced geometry so whole frames fit in a
// short run; an active-low and an active-high sync instance run in lockstep.
module tb_video_timing_gen;

  localparam int CW = 10;
  localparam int M0_H_ACT = 12, M0_H_FP = 2, M0_H_SYNC = 3, M0_H_BP = 2;
  localparam int M0_V_ACT = 6,  M0_V_FP = 1, M0_V_SYNC = 2, M0_V_BP = 1;
  localparam int M1_H_ACT = 16, M1_H_FP = 2, M1_H_SYNC = 4, M1_H_BP = 3;
  localparam int M1_V_ACT = 8,  M1_V_FP = 2, M1_V_SYNC = 1, M1_V_BP = 2;
  localparam int M0_HT = M0_H_ACT + M0_H_FP + M0_H_SYNC + M0_H_BP;
  localparam int M0_VT = M0_V_ACT + M0_V_FP + M0_V_SYNC + M0_V_BP;
  localparam int M1_HT = M1_H_ACT + M1_H_FP + M1_H_SYNC + M1_H_BP;
  localparam int M1_VT = M1_V_ACT + M1_V_FP + M1_V_SYNC + M1_V_BP;

  typedef struct packed {
    logic          mode;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          hs, vs, hb, vb, act, ls, fs;
  } out_t;

  logic clk = 1'b0;
  logic i_Reset = 1'b1, i_Pix_En = 1'b0, i_Mode = 1'b0;

  logic          o_Mode, o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active, o_Line_Start, o_Frame_Start;
  logic [CW-1:0] o_Col_Count, o_Row_Count;
  logic          p_Mode, p_HSync, p_VSync, p_HBlank, p_VBlank, p_Active, p_Line_Start, p_Frame_Start;
  logic [CW-1:0] p_Col_Count, p_Row_Count;

  int checks = 0;
  int errors = 0;

  out_t sbq[$];
  out_t last_exp;
  int   m_col = 0, m_row = 0;
  logic m_mode = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .COUNT_WIDTH(CW), .HSYNC_POL(0), .VSYNC_POL(0),
    .M0_H_ACT(M0_H_ACT), .M0_H_FP(M0_H_FP), .M0_H_SYNC(M0_H_SYNC), .M0_H_BP(M0_H_BP),
    .M0_V_ACT(M0_V_ACT), .M0_V_FP(M0_V_FP), .M0_V_SYNC(M0_V_SYNC), .M0_V_BP(M0_V_BP),
    .M1_H_ACT(M1_H_ACT), .M1_H_FP(M1_H_FP), .M1_H_SYNC(M1_H_SYNC), .M1_H_BP(M1_H_BP),
    .M1_V_ACT(M1_V_ACT), .M1_V_FP(M1_V_FP), .M1_V_SYNC(M1_V_SYNC), .M1_V_BP(M1_V_BP)
  ) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En), .i_Mode(i_Mode),
    .o_Mode(o_Mode), .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_HSync(o_HSync), .o_VSync(o_VSync), .o_HBlank(o_HBlank), .o_VBlank(o_VBlank),
    .o_Active(o_Active), .o_Line_Start(o_Line_Start), .o_Frame_Start(o_Frame_Start)
  );

  video_timing_gen #(
    .COUNT_WIDTH(CW), .HSYNC_POL(1), .VSYNC_POL(1),
    .M0_H_ACT(M0_H_ACT), .M0_H_FP(M0_H_FP), .M0_H_SYNC(M0_H_SYNC), .M0_H_BP(M0_H_BP),
    .M0_V_ACT(M0_V_ACT), .M0_V_FP(M0_V_FP), .M0_V_SYNC(M0_V_SYNC), .M0_V_BP(M0_V_BP),
    .M1_H_ACT(M1_H_ACT), .M1_H_FP(M1_H_FP), .M1_H_SYNC(M1_H_SYNC), .M1_H_BP(M1_H_BP),
    .M1_V_ACT(M1_V_ACT), .M1_V_FP(M1_V_FP), .M1_V_SYNC(M1_V_SYNC), .M1_V_BP(M1_V_BP)
  ) dut_p (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En), .i_Mode(i_Mode),
    .o_Mode(p_Mode), .o_Col_Count(p_Col_Count), .o_Row_Count(p_Row_Count),
    .o_HSync(p_HSync), .o_VSync(p_VSync), .o_HBlank(p_HBlank), .o_VBlank(p_VBlank),
    .o_Active(p_Active), .o_Line_Start(p_Line_Start), .o_Frame_Start(p_Frame_Start)
  );

  // Reference pixel description for a (col,row) in a given mode, active-low syncs.
  function automatic out_t model_decode(input int c, input int r, input logic m);
    out_t o;
    int ha, hs0, hs1, va, vs0, vs1;
    ha  = m ? M1_H_ACT : M0_H_ACT;
    hs0 = ha + (m ? M1_H_FP : M0_H_FP);
    hs1 = hs0 + (m ? M1_H_SYNC : M0_H_SYNC);
    va  = m ? M1_V_ACT : M0_V_ACT;
    vs0 = va + (m ? M1_V_FP : M0_V_FP);
    vs1 = vs0 + (m ? M1_V_SYNC : M0_V_SYNC);
    o.mode = m;
    o.col  = CW'(c);
    o.row  = CW'(r);
    o.hs   = !(c >= hs0 && c < hs1);
    o.vs   = !(r >= vs0 && r < vs1);
    o.hb   = (c >= ha);
    o.vb   = (r >= va);
    o.act  = (c < ha) && (r < va);
    o.ls   = (c == 0);
    o.fs   = (c == 0) && (r == 0);
    return o;
  endfunction

  function automatic out_t reset_value(input logic m);
    out_t o;
    o = '0;
    o.mode = m;
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.hb = 1'b1;
    o.vb = 1'b1;
    return o;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, compare both instances after the edge.
  task automatic tick(input logic en, input logic md, input logic rs);
    out_t e, ep, obs, obs_p;
    int   ht, vt;
    i_Pix_En = en;
    i_Mode   = md;
    i_Reset  = rs;
    if (rs) begin
      e = reset_value(md);
      m_col = 0;
      m_row = 0;
      m_mode = md;
    end else if (en) begin
      e  = model_decode(m_col, m_row, m_mode);
      ht = m_mode ? M1_HT : M0_HT;
      vt = m_mode ? M1_VT : M0_VT;
      if (m_col == ht - 1) begin
        m_col = 0;
        if (m_row == vt - 1) begin
          m_row = 0;
          m_mode = md;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end else begin
      e = last_exp;
    end
    last_exp = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    obs   = {o_Mode, o_Col_Count, o_Row_Count, o_HSync, o_VSync, o_HBlank, o_VBlank,
             o_Active, o_Line_Start, o_Frame_Start};
    obs_p = {p_Mode, p_Col_Count, p_Row_Count, p_HSync, p_VSync, p_HBlank, p_VBlank,
             p_Active, p_Line_Start, p_Frame_Start};
    ep = e;
    ep.hs = ~e.hs;
    ep.vs = ~e.vs;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL outputs: observed %h expected %h", obs, e);
    end
    checks++;
    assert (obs_p === ep) else begin
      errors++;
      $error("FAIL outputs_pol1: observed %h expected %h", obs_p, ep);
    end
  endtask

  // Runs the rest of a frame after its o_Frame_Start cycle and checks the next one.
  task automatic run_frame(input string tag, input logic md, input int tot, input int ht,
                           input int ha, input int hs0, input int hsn, input int vs0,
                           input int vsn);
    int hs_first = -1, hs_cnt = 0, hb_first = -1, vs_first = -1, vs_cnt = 0;
    int fs_cnt = 0, ls_cnt = 0;
    for (int i = 1; i < tot; i++) begin
      tick(1'b1, md, 1'b0);
      if (o_Frame_Start) fs_cnt++;
      if (o_Row_Count == '0) begin
        if (!o_HSync) begin
          if (hs_first < 0) hs_first = int'(o_Col_Count);
          hs_cnt++;
        end
        if (o_HBlank && hb_first < 0) hb_first = int'(o_Col_Count);
      end
      if (o_Line_Start) begin
        ls_cnt++;
        if (!o_VSync) begin
          if (vs_first < 0) vs_first = int'(o_Row_Count);
          vs_cnt++;
        end
      end
    end
    check({tag, "_no_early_fs"}, fs_cnt, 0);
    check({tag, "_hblank_col"}, hb_first, ha);
    check({tag, "_hsync_col"}, hs_first, hs0);
    check({tag, "_hsync_len"}, hs_cnt, hsn);
    check({tag, "_vsync_row"}, vs_first, vs0);
    check({tag, "_vsync_len"}, vs_cnt, vsn);
    check({tag, "_lines"}, ls_cnt, tot / ht - 1);
    tick(1'b1, md, 1'b0);
    check({tag, "_next_fs"}, int'(o_Frame_Start), 1);
    check({tag, "_next_ls"}, int'(o_Line_Start), 1);
    check({tag, "_next_col"}, int'(o_Col_Count), 0);
    check({tag, "_next_row"}, int'(o_Row_Count), 0);
    check({tag, "_next_mode"}, int'(o_Mode), int'(md));
  endtask

  initial begin
    int row_max;
    int fs_clks;
    last_exp = reset_value(1'b0);

    // Reset state in mode 0, applied with and without the pixel enable.
    tick(1'b0, 1'b0, 1'b1);
    check("rst_hblank", int'(o_HBlank), 1);
    check("rst_active", int'(o_Active), 0);
    check("rst_hsync", int'(o_HSync), 1);
    check("rst_hsync_pol1", int'(p_HSync), 0);
    tick(1'b1, 1'b0, 1'b1);
    check("rst_fs", int'(o_Frame_Start), 0);

    tick(1'b1, 1'b0, 1'b0);
    check("first_fs", int'(o_Frame_Start), 1);
    check("first_ls", int'(o_Line_Start), 1);
    check("first_active", int'(o_Active), 1);
    run_frame("m0", 1'b0, M0_HT * M0_VT, M0_HT, M0_H_ACT, M0_H_ACT + M0_H_FP, M0_H_SYNC,
              M0_V_ACT + M0_V_FP, M0_V_SYNC);

    // A mode request that reverts before the frame end must be ignored.
    for (int i = 1; i < M0_HT * M0_VT; i++) tick(1'b1, (i >= 40 && i < 70), 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("revert_fs", int'(o_Frame_Start), 1);
    check("revert_mode", int'(o_Mode), 0);

    // Request mode 1 around row 3; the mode 0 frame still finishes.
    row_max = 0;
    for (int i = 1; i < M0_HT * M0_VT; i++) begin
      tick(1'b1, (i >= 3 * M0_HT), 1'b0);
      if (int'(o_Row_Count) > row_max) row_max = int'(o_Row_Count);
      if (i == 3 * M0_HT + 1) check("switch_pending_mode", int'(o_Mode), 0);
    end
    check("switch_last_row", row_max, M0_VT - 1);
    tick(1'b1, 1'b1, 1'b0);
    check("switch_fs", int'(o_Frame_Start), 1);
    check("switch_mode", int'(o_Mode), 1);
    run_frame("m1", 1'b1, M1_HT * M1_VT, M1_HT, M1_H_ACT, M1_H_ACT + M1_H_FP, M1_H_SYNC,
              M1_V_ACT + M1_V_FP, M1_V_SYNC);

    // Pixel enable one clock in four: the frame strobe spans one enabled period.
    fs_clks = 0;
    for (int k = 0; k < M1_HT * M1_VT; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (o_Frame_Start) fs_clks++;
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, 1'b1, 1'b0);
        if (o_Frame_Start) fs_clks++;
      end
    end
    check("slow_fs_clocks", fs_clks, 4);

    // Reset mid-frame with a pending mode 0 request; reset samples mode 1 instead.
    for (int i = 0; i < 150; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    check("midrst_col", int'(o_Col_Count), 0);
    check("midrst_vblank", int'(o_VBlank), 1);
    check("midrst_mode", int'(o_Mode), 1);
    tick(1'b0, 1'b1, 1'b0);
    check("midrst_hold_fs", int'(o_Frame_Start), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("midrst_fs", int'(o_Frame_Start), 1);
    check("midrst_ls", int'(o_Line_Start), 1);
    check("midrst_mode_kept", int'(o_Mode), 1);
    run_frame("m1b", 1'b1, M1_HT * M1_VT, M1_HT, M1_H_ACT, M1_H_ACT + M1_H_FP, M1_H_SYNC,
              M1_V_ACT + M1_V_FP, M1_V_SYNC);

    // Reset straight into mode 0 again.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check("rst0_fs", int'(o_Frame_Start), 1);
    check("rst0_mode", int'(o_Mode), 0);
    run_frame("m0b", 1'b0, M0_HT * M0_VT, M0_HT, M0_H_ACT, M0_H_ACT + M0_H_FP, M0_H_SYNC,
              M0_V_ACT + M0_V_FP, M0_V_SYNC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
